vram_port_arbiter: RTL and testbench

- Shares one single-port pixel/tile block RAM between three requesters:
  - req0: display line fetch, which feeds the pixel buffer ahead of the TMDS encoder.
  - req1: sprite fetch.
  - req2: game-logic write/read.
- Sits in the 100 MHz base domain between the fetch/logic engines and the RAM.
- Issues one RAM command per cycle in granted bursts and routes read data back with a per-requester valid.
- Fixed priority for req0; round-robin between req1 and req2.

---
 rtl/vram_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_vram_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM arbiter: req0 (display fetch) has fixed priority with unlimited bursts,
// req1/req2 share round-robin bursts of up to pBurstLen beats; read data returns with a per-requester valid.
//
// state | meaning
// IDLE  | no grant, waiting for any request
// BURST | one requester granted, one beat per cycle while it requests
// ARB   | one idle command cycle after a burst (RAM turnaround), re-arbitrates
module vram_port_arbiter #(
   parameter int pAddrW     = 16,
   parameter int pDataW     = 24,
   parameter int pBurstLen  = 16,
   parameter int pRdLatency = 2
) (
   input  logic                iCLK,
   input  logic                iRST,
   input  logic [2:0]          iReq,
   input  logic [3*pAddrW-1:0] iAddr,
   input  logic                iWe2,
   input  logic [pDataW-1:0]   iWd2,
   output logic [2:0]          oGnt,
   output logic                oMemEn,
   output logic                oMemWe,
   output logic [pAddrW-1:0]   oMemAddr,
   output logic [pDataW-1:0]   oMemWd,
   input  logic [pDataW-1:0]   iMemRd,
   output logic [2:0]          oRdVld,
   output logic [pDataW-1:0]   oRdData,
   output logic                oBusy
);

   typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_ARB} state_t;

   localparam logic [7:0] LastBeat = 8'(pBurstLen - 1);

   logic [1:0]                  rst_sync_q;
   logic                        run;
   state_t                      state_q, state_d;
   logic [2:0]                  gnt_q, gnt_d;
   logic                        ptr_q, ptr_d;
   logic [7:0]                  cnt_q, cnt_d;
   logic                        mem_en_q, mem_en_d;
   logic                        mem_we_q, mem_we_d;
   logic [pAddrW-1:0]           mem_addr_q, mem_addr_d;
   logic [pDataW-1:0]           mem_wd_q, mem_wd_d;
   logic [pRdLatency:0][2:0]    tag_q, tag_d;
   logic [2:0]                  rd_vld_q, rd_vld_d;
   logic [pDataW-1:0]           rd_data_q, rd_data_d;
   logic [2:0]                  winner;
   logic [pAddrW-1:0]           beat_addr;
   logic                        beat_acc;
   logic                        beat_rd;
   logic                        burst_end;

   // Reset release is synchronised; the core holds until both stages have seen it.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) rst_sync_q <= 2'b00;
      else       rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   assign run = rst_sync_q[1];

   // ptr_q = 0 favours req1, 1 favours req2.
   always_comb begin
      winner = 3'b000;
      if (iReq[0])     winner = 3'b001;
      else if (!ptr_q) winner = iReq[1] ? 3'b010 : 3'b100;
      else             winner = iReq[2] ? 3'b100 : 3'b010;
   end

   always_comb begin
      beat_addr = iAddr[2*pAddrW +: pAddrW];
      if (gnt_q[0])      beat_addr = iAddr[0 +: pAddrW];
      else if (gnt_q[1]) beat_addr = iAddr[pAddrW +: pAddrW];
   end

   assign beat_acc  = |(gnt_q & iReq);
   assign beat_rd   = beat_acc && !(gnt_q[2] && iWe2);
   assign burst_end = !beat_acc || (!gnt_q[0] && (iReq[0] || cnt_q == LastBeat));

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      mem_en_d   = 1'b0;
      mem_we_d   = 1'b0;
      mem_addr_d = mem_addr_q;
      mem_wd_d   = mem_wd_q;
      case (state_q)
         ST_IDLE, ST_ARB: begin
            if (|iReq) begin
               gnt_d   = winner;
               cnt_d   = 8'd0;
               state_d = ST_BURST;
            end else begin
               gnt_d   = 3'b000;
               state_d = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (beat_acc) begin
               mem_en_d   = 1'b1;
               mem_addr_d = beat_addr;
               cnt_d      = cnt_q + 8'd1;
               if (gnt_q[2]) begin
                  mem_we_d = iWe2;
                  mem_wd_d = iWd2;
               end
            end
            if (burst_end) begin
               gnt_d   = 3'b000;
               state_d = ST_ARB;
               if (!gnt_q[0]) ptr_d = gnt_q[1];
            end
         end
         default: begin
            gnt_d   = 3'b000;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Owner tag rides alongside each read command until its data is registered.
   always_comb begin
      tag_d     = {tag_q[pRdLatency-1:0], (beat_rd ? gnt_q : 3'b000)};
      rd_vld_d  = tag_q[pRdLatency];
      rd_data_d = iMemRd;
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q    <= ST_IDLE;
         gnt_q      <= 3'b000;
         ptr_q      <= 1'b0;
         cnt_q      <= 8'd0;
         mem_en_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_wd_q   <= '0;
         tag_q      <= '0;
         rd_vld_q   <= 3'b000;
         rd_data_q  <= '0;
      end else if (run) begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         mem_en_q   <= mem_en_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_wd_q   <= mem_wd_d;
         tag_q      <= tag_d;
         rd_vld_q   <= rd_vld_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign oGnt     = gnt_q;
   assign oMemEn   = mem_en_q;
   assign oMemWe   = mem_we_q;
   assign oMemAddr = mem_addr_q;
   assign oMemWd   = mem_wd_q;
   assign oRdVld   = rd_vld_q;
   assign oRdData  = rd_data_q;
   assign oBusy    = (state_q == ST_BURST);

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter: requester model, latency-2 RAM model and
// per-cycle command/read-return checks, plus grant-run checks per scenario.
module tb_vram_port_arbiter;

   localparam int AW = 16;
   localparam int DW = 24;
   localparam int BL = 16;
   localparam int RL = 2;

   logic            iCLK = 1'b0;
   logic            iRST;
   logic [2:0]      iReq;
   logic [3*AW-1:0] iAddr;
   logic            iWe2;
   logic [DW-1:0]   iWd2;
   logic [2:0]      oGnt;
   logic            oMemEn;
   logic            oMemWe;
   logic [AW-1:0]   oMemAddr;
   logic [DW-1:0]   oMemWd;
   logic [DW-1:0]   iMemRd;
   logic [2:0]      oRdVld;
   logic [DW-1:0]   oRdData;
   logic            oBusy;

   vram_port_arbiter #(
      .pAddrW(AW), .pDataW(DW), .pBurstLen(BL), .pRdLatency(RL)
   ) u_dut (
      .iCLK(iCLK), .iRST(iRST), .iReq(iReq), .iAddr(iAddr), .iWe2(iWe2), .iWd2(iWd2),
      .oGnt(oGnt), .oMemEn(oMemEn), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemWd(oMemWd),
      .iMemRd(iMemRd), .oRdVld(oRdVld), .oRdData(oRdData), .oBusy(oBusy)
   );

   always #5 iCLK = ~iCLK;

   int n_chk = 0;
   int n_fail = 0;

   int            rem [3];
   logic [AW-1:0] addr [3];
   int            beats [3];
   int            rd_cnt [3];
   logic [2:0]    rd_own [8];
   logic [AW-1:0] rd_adr [8];
   int            cyc;
   logic          p0_v, p1_v;
   logic [AW-1:0] p0_a, p1_a;
   logic [2:0]    run_gnt [32];
   int            run_beats [32];
   int            run_gap [32];
   int            n_runs;
   logic [2:0]    cur_gnt;
   int            cur_beats, cur_gap, gap_cnt;
   int            cmd_cnt;
   logic [AW-1:0] last_cmd_addr;
   int            first_en_cyc, first_vld_cyc, first_gnt_cyc, first_g0_cyc;
   int            rel_cyc, rise_cyc;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic apply_req();
      for (int i = 0; i < 3; i++) iReq[i] = (rem[i] > 0);
      iAddr = {addr[2], addr[1], addr[0]};
   endtask

   task automatic clear_tracking();
      for (int i = 0; i < 8; i++) begin
         rd_own[i] = 3'b000;
         rd_adr[i] = '0;
      end
      for (int i = 0; i < 3; i++) begin
         rem[i]    = 0;
         beats[i]  = 0;
         rd_cnt[i] = 0;
      end
      for (int i = 0; i < 32; i++) begin
         run_gnt[i]   = 3'b000;
         run_beats[i] = 0;
         run_gap[i]   = 0;
      end
      p0_v = 1'b0; p1_v = 1'b0; p0_a = '0; p1_a = '0;
      n_runs = 0; cur_gnt = 3'b000; cur_beats = 0; cur_gap = 0; gap_cnt = 0;
      cmd_cnt = 0; last_cmd_addr = '0;
      first_en_cyc = -1; first_vld_cyc = -1; first_gnt_cyc = -1; first_g0_cyc = -1;
      apply_req();
   endtask

   // One clock: predict the command from what is accepted this cycle, then check after the edge.
   task automatic run_cycle();
      logic [2:0]    acc;
      logic [AW-1:0] eaddr;
      logic          ewe;
      logic [DW-1:0] ewd;
      logic          c_v;
      logic [AW-1:0] c_a;
      logic [2:0]    erd;
      logic [2:0]    g;
      acc   = oGnt & iReq;
      eaddr = acc[0] ? addr[0] : (acc[1] ? addr[1] : addr[2]);
      ewe   = acc[2] & iWe2;
      ewd   = iWd2;
      c_v   = oMemEn & ~oMemWe;
      c_a   = oMemAddr;
      @(posedge iCLK);
      #1;
      cyc++;
      p1_v = p0_v; p1_a = p0_a; p0_v = c_v; p0_a = c_a;
      iMemRd = p1_v ? {8'hA5, p1_a} : 24'hDEAD00;

      check_val("mem_en", 32'(oMemEn), 32'(|acc));
      if (|acc) begin
         check_val("mem_addr", 32'(oMemAddr), 32'(eaddr));
         check_val("mem_we", 32'(oMemWe), 32'(ewe));
         if (ewe) check_val("mem_wd", 32'(oMemWd), 32'(ewd));
      end
      erd = ((|acc) && !ewe) ? acc : 3'b000;
      rd_own[3'(cyc)] = erd;
      rd_adr[3'(cyc)] = eaddr;
      check_val("rd_vld", 32'(oRdVld), 32'(rd_own[3'(cyc - RL - 1)]));
      if (|rd_own[3'(cyc - RL - 1)])
         check_val("rd_data", 32'(oRdData), 32'({8'hA5, rd_adr[3'(cyc - RL - 1)]}));

      for (int i = 0; i < 3; i++) if (oRdVld[i]) rd_cnt[i]++;
      if (oMemEn) begin
         cmd_cnt++;
         last_cmd_addr = oMemAddr;
         if (first_en_cyc < 0) first_en_cyc = cyc;
      end
      if ((|oRdVld) && first_vld_cyc < 0) first_vld_cyc = cyc;
      if ((oGnt != 3'b000) && first_gnt_cyc < 0) first_gnt_cyc = cyc;
      if ((oGnt == 3'b001) && first_g0_cyc < 0) first_g0_cyc = cyc;

      for (int i = 0; i < 3; i++) begin
         if (acc[i]) begin
            beats[i]++;
            rem[i]--;
            addr[i] = addr[i] + 1'b1;
         end
      end
      apply_req();

      if (|acc) cur_beats++;
      g = oGnt;
      if (g != cur_gnt) begin
         if (cur_gnt != 3'b000 && n_runs < 32) begin
            run_gnt[n_runs]   = cur_gnt;
            run_beats[n_runs] = cur_beats;
            run_gap[n_runs]   = cur_gap;
            n_runs++;
         end
         if (g != 3'b000) begin
            cur_gap   = gap_cnt;
            gap_cnt   = 0;
            cur_beats = 0;
         end
         cur_gnt = g;
      end
      if (g == 3'b000) gap_cnt++;
   endtask

   task automatic assert_reset();
      iRST = 1'b0;
      #1;
      check_val("rst_gnt", 32'(oGnt), 32'd0);
      check_val("rst_mem_en", 32'(oMemEn), 32'd0);
      check_val("rst_mem_we", 32'(oMemWe), 32'd0);
      check_val("rst_mem_addr", 32'(oMemAddr), 32'd0);
      check_val("rst_mem_wd", 32'(oMemWd), 32'd0);
      check_val("rst_rd_vld", 32'(oRdVld), 32'd0);
      check_val("rst_rd_data", 32'(oRdData), 32'd0);
      check_val("rst_busy", 32'(oBusy), 32'd0);
      clear_tracking();
   endtask

   task automatic release_reset();
      run_cycle();
      iRST    = 1'b1;
      rel_cyc = cyc;
      run_cycle();
      check_val("sync_edge1_gnt", 32'(oGnt), 32'd0);
   endtask

   task automatic check_run(input int k, input logic [2:0] g, input int b, input int gap);
      check_val($sformatf("run%0d_gnt", k), 32'(run_gnt[k]), 32'(g));
      check_val($sformatf("run%0d_beats", k), 32'(run_beats[k]), 32'(b));
      if (gap >= 0) check_val($sformatf("run%0d_gap", k), 32'(run_gap[k]), 32'(gap));
   endtask

   initial begin
      iRST = 1'b1; iReq = 3'b000; iAddr = '0; iWe2 = 1'b0; iWd2 = '0; iMemRd = '0;
      cyc = 16; rel_cyc = 0; rise_cyc = 0;
      for (int i = 0; i < 3; i++) addr[i] = '0;
      #2;

      // req1 alone, one full burst
      assert_reset();
      rem[1] = 16; addr[1] = 16'h0100; apply_req();
      release_reset();
      repeat (40) run_cycle();
      check_val("t1_runs", 32'(n_runs), 32'd1);
      check_run(0, 3'b010, 16, -1);
      check_val("t1_last_addr", 32'(last_cmd_addr), 32'h010F);
      check_val("t1_cmds", 32'(cmd_cnt), 32'd16);
      check_val("t1_rd1", 32'(rd_cnt[1]), 32'd16);
      check_val("t1_rd_lat", 32'(first_vld_cyc - first_en_cyc), 32'd3);
      check_val("t1_gnt_idle", 32'(oGnt), 32'd0);
      check_val("t1_busy_idle", 32'(oBusy), 32'd0);

      // req1 reads vs req2 writes under continuous contention
      assert_reset();
      rem[1] = 32; addr[1] = 16'h1000; rem[2] = 32; addr[2] = 16'h2000;
      iWe2 = 1'b1; iWd2 = 24'hFF00FF; apply_req();
      release_reset();
      repeat (90) run_cycle();
      check_val("t2_runs", 32'(n_runs), 32'd4);
      check_run(0, 3'b010, 16, -1);
      check_run(1, 3'b100, 16, 1);
      check_run(2, 3'b010, 16, 1);
      check_run(3, 3'b100, 16, 1);
      check_val("t2_cmds", 32'(cmd_cnt), 32'd64);
      check_val("t2_rd1", 32'(rd_cnt[1]), 32'd32);
      check_val("t2_rd2", 32'(rd_cnt[2]), 32'd0);

      // req0 preempts req1 at beat 5
      assert_reset();
      iWe2 = 1'b0;
      rem[1] = 30; addr[1] = 16'h0300; addr[0] = 16'h0400; apply_req();
      release_reset();
      for (int k = 0; k < 40 && beats[1] < 5; k++) run_cycle();
      check_val("t3_reach_beat5", 32'(beats[1]), 32'd5);
      rem[0] = 4; apply_req();
      rise_cyc = cyc;
      repeat (60) run_cycle();
      check_val("t3_lat_le3", 32'((first_g0_cyc - rise_cyc) <= 3 && first_g0_cyc > rise_cyc), 32'd1);
      check_val("t3_runs", 32'(n_runs), 32'd4);
      check_run(0, 3'b010, 6, -1);
      check_run(1, 3'b001, 4, 1);
      check_run(2, 3'b010, 16, 1);
      check_run(3, 3'b010, 8, 1);
      check_val("t3_rd0", 32'(rd_cnt[0]), 32'd4);
      check_val("t3_rd1", 32'(rd_cnt[1]), 32'd30);

      // req0 long burst, no length limit
      assert_reset();
      rem[0] = 700; addr[0] = 16'h4000; rem[1] = 5; addr[1] = 16'h5000;
      rem[2] = 5; addr[2] = 16'h6000; apply_req();
      release_reset();
      repeat (750) run_cycle();
      check_val("t4_runs", 32'(n_runs), 32'd3);
      check_run(0, 3'b001, 700, -1);
      check_run(1, 3'b010, 5, 1);
      check_run(2, 3'b100, 5, 1);
      check_val("t4_rd0", 32'(rd_cnt[0]), 32'd700);
      check_val("t4_rd2", 32'(rd_cnt[2]), 32'd5);

      // asynchronous reset with reads in flight
      assert_reset();
      rem[1] = 20; addr[1] = 16'h0500; apply_req();
      release_reset();
      for (int k = 0; k < 40 && beats[1] < 4; k++) run_cycle();
      check_val("t5_reach_beat4", 32'(beats[1]), 32'd4);
      #2;
      assert_reset();
      rem[1] = 10; addr[1] = 16'h0600; apply_req();
      run_cycle();
      release_reset();
      repeat (30) run_cycle();
      check_val("t5_first_gnt_ge2", 32'((first_gnt_cyc - rel_cyc) >= 2), 32'd1);
      check_val("t5_rd1", 32'(rd_cnt[1]), 32'd10);
      check_val("t5_rd0", 32'(rd_cnt[0]), 32'd0);

      // req2 drops after 3 beats; pointer returns to req1
      assert_reset();
      rem[1] = 2; addr[1] = 16'h0700; rem[2] = 3; addr[2] = 16'h0800; apply_req();
      release_reset();
      repeat (20) run_cycle();
      rem[1] = 2; addr[1] = 16'h0710; rem[2] = 2; addr[2] = 16'h0810; apply_req();
      repeat (20) run_cycle();
      check_val("t6_runs", 32'(n_runs), 32'd4);
      check_run(0, 3'b010, 2, -1);
      check_run(1, 3'b100, 3, 1);
      check_run(2, 3'b010, 2, -1);
      check_run(3, 3'b100, 2, 1);
      check_val("t6_rd2", 32'(rd_cnt[2]), 32'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
